// File: rtl/riscv_mem_arbiter_if.sv
// Unified memory bus between the fetch/data arbiter and the memory model.
// The master side issues a level-held request; the slave answers with a one-cycle ack.
interface riscv_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [1:0]        size;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata, size,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata, size,
    output ack, rdata
  );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Fetch/data arbiter for one single-port memory bus.
// Data has priority, capped by a streak limit so a pending fetch always gets through.
module riscv_mem_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_inst_rd_en,
  input  logic [ADDR_W-1:0] i_inst_addr,
  output logic              o_instr_ready,
  output logic [DATA_W-1:0] o_instr_data,
  input  logic              i_data_rd_en,
  input  logic              i_data_wr_en,
  input  logic [ADDR_W-1:0] i_data_addr,
  input  logic [DATA_W-1:0] i_data_wr,
  input  logic [1:0]        i_data_size,
  output logic              o_data_ready,
  output logic [DATA_W-1:0] o_data_rd,
  riscv_mem_arbiter_if.master mem
);

  typedef enum logic [1:0] {
    IDLE,
    INST_BUSY,
    DATA_BUSY,
    RESP
  } state_e;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

  state_e            state_q, state_d;
  logic [3:0]        streak_q, streak_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic              instr_ready_q, instr_ready_d;
  logic [DATA_W-1:0] instr_data_q, instr_data_d;
  logic              data_ready_q, data_ready_d;
  logic [DATA_W-1:0] data_rd_q, data_rd_d;

  logic data_pend;
  logic data_win;

  assign data_pend = i_data_rd_en | i_data_wr_en;
  assign data_win  = data_pend &
                     (~i_inst_rd_en | (streak_q < STREAK_MAX));

  always_comb begin
    state_d       = state_q;
    streak_d      = streak_q;
    req_d         = req_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    size_d        = size_q;
    instr_ready_d = 1'b0;
    instr_data_d  = instr_data_q;
    data_ready_d  = 1'b0;
    data_rd_d     = data_rd_q;

    case (state_q)
      IDLE: begin
        req_d = 1'b0;
        if (data_win) begin
          state_d = DATA_BUSY;
          req_d   = 1'b1;
          we_d    = i_data_wr_en;
          addr_d  = i_data_addr;
          wdata_d = i_data_wr;
          size_d  = i_data_size;
          // streak only counts data wins that held a fetch back
          if (i_inst_rd_en) begin
            streak_d = (streak_q == 4'hF) ? 4'hF : streak_q + 4'd1;
          end else begin
            streak_d = '0;
          end
        end else if (i_inst_rd_en) begin
          state_d  = INST_BUSY;
          req_d    = 1'b1;
          we_d     = 1'b0;
          addr_d   = i_inst_addr;
          size_d   = 2'b10;
          streak_d = '0;
        end
      end
      INST_BUSY: begin
        if (mem.ack) begin
          state_d       = RESP;
          req_d         = 1'b0;
          instr_ready_d = 1'b1;
          instr_data_d  = mem.rdata;
        end
      end
      DATA_BUSY: begin
        if (mem.ack) begin
          state_d      = RESP;
          req_d        = 1'b0;
          data_ready_d = 1'b1;
          if (!we_q) begin
            data_rd_d = mem.rdata;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      streak_q      <= '0;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      size_q        <= '0;
      instr_ready_q <= 1'b0;
      instr_data_q  <= '0;
      data_ready_q  <= 1'b0;
      data_rd_q     <= '0;
    end else begin
      state_q       <= state_d;
      streak_q      <= streak_d;
      req_q         <= req_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      size_q        <= size_d;
      instr_ready_q <= instr_ready_d;
      instr_data_q  <= instr_data_d;
      data_ready_q  <= data_ready_d;
      data_rd_q     <= data_rd_d;
    end
  end

  assign mem.req       = req_q;
  assign mem.we        = we_q;
  assign mem.addr      = addr_q;
  assign mem.wdata     = wdata_q;
  assign mem.size      = size_q;
  assign o_instr_ready = instr_ready_q;
  assign o_instr_data  = instr_data_q;
  assign o_data_ready  = data_ready_q;
  assign o_data_rd     = data_rd_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Bench for riscv_mem_arbiter: directed scenarios, then randomized traffic
// checked against a transaction-level model of the arbitration rules.
module tb_riscv_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_inst_rd_en = 1'b0;
  logic [AW-1:0] i_inst_addr = '0;
  logic          o_instr_ready;
  logic [DW-1:0] o_instr_data;
  logic          i_data_rd_en = 1'b0;
  logic          i_data_wr_en = 1'b0;
  logic [AW-1:0] i_data_addr = '0;
  logic [DW-1:0] i_data_wr = '0;
  logic [1:0]    i_data_size = '0;
  logic          o_data_ready;
  logic [DW-1:0] o_data_rd;

  riscv_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mem ();

  riscv_mem_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .MAX_DATA_STREAK(MAXS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_inst_rd_en(i_inst_rd_en),
    .i_inst_addr(i_inst_addr),
    .o_instr_ready(o_instr_ready),
    .o_instr_data(o_instr_data),
    .i_data_rd_en(i_data_rd_en),
    .i_data_wr_en(i_data_wr_en),
    .i_data_addr(i_data_addr),
    .i_data_wr(i_data_wr),
    .i_data_size(i_data_size),
    .o_data_ready(o_data_ready),
    .o_data_rd(o_data_rd),
    .mem(mem)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // transaction-level model: 0 free, 1 access outstanding, 2 completion cycle
  int          phase = 0;
  bit          kind_d = 1'b0;
  int          streak = 0;
  bit          new_grant = 1'b0;
  logic        e_we;
  logic [31:0] e_addr, e_wdata;
  logic [1:0]  e_size;
  logic [31:0] m_instr = '0;
  logic [31:0] m_drd = '0;

  int          delay = 0;
  bit          d_hold = 1'b0;
  bit          i_hold = 1'b0;
  int          cyc = 0;
  int          req_rise = 0;
  int          req_hi = 0;
  bit          prev_req = 1'b0;
  int          d_ready_cyc = 0;
  int          i_ready_cyc = 0;
  logic [31:0] dut_log[$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit          dp, fp, rs, ak, dwr;
    logic [31:0] rd_s, da, dw, ia;
    logic [1:0]  ds;
    dp   = i_data_rd_en | i_data_wr_en;
    fp   = i_inst_rd_en;
    dwr  = i_data_wr_en;
    rs   = rst;
    ak   = mem.ack;
    rd_s = mem.rdata;
    da   = i_data_addr;
    dw   = i_data_wr;
    ds   = i_data_size;
    ia   = i_inst_addr;
    new_grant = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    if (rs) begin
      phase   = 0;
      streak  = 0;
      m_instr = '0;
      m_drd   = '0;
      chk("rst_we", mem.we, 0);
      chk("rst_addr", mem.addr, 0);
      chk("rst_wdata", mem.wdata, 0);
      chk("rst_size", mem.size, 0);
    end else if (phase == 0) begin
      if (dp || fp) begin
        kind_d = dp && (!fp || streak < MAXS);
        if (kind_d) begin
          streak  = fp ? ((streak < 15) ? streak + 1 : 15) : 0;
          e_we    = dwr;
          e_addr  = da;
          e_wdata = dw;
          e_size  = ds;
        end else begin
          streak = 0;
          e_we   = 1'b0;
          e_addr = ia;
          e_size = 2'b10;
        end
        phase     = 1;
        new_grant = 1'b1;
      end
    end else if (phase == 1) begin
      if (ak) begin
        phase = 2;
        if (!kind_d) m_instr = rd_s;
        else if (!e_we) m_drd = rd_s;
      end
    end else begin
      phase = 0;
    end

    chk("mem_req", mem.req, phase == 1);
    if (phase == 1) begin
      chk("mem_we", mem.we, e_we);
      chk("mem_addr", mem.addr, e_addr);
      chk("mem_size", mem.size, e_size);
      if (kind_d) chk("mem_wdata", mem.wdata, e_wdata);
    end
    chk("instr_ready", o_instr_ready, phase == 2 && !kind_d);
    chk("data_ready", o_data_ready, phase == 2 && kind_d);
    chk("instr_data", o_instr_data, m_instr);
    chk("data_rd", o_data_rd, m_drd);

    if (mem.req && !prev_req) begin
      req_rise++;
      dut_log.push_back(mem.addr);
    end
    prev_req = mem.req;
    if (mem.req) req_hi++;
    if (o_data_ready) d_ready_cyc = cyc;
    if (o_instr_ready) i_ready_cyc = cyc;
  endtask

  // mode 0: random traffic, 1: saturating load+fetch, 2: drain
  task automatic auto_drive(input int mode);
    int r;
    if (mode == 1) begin
      i_data_rd_en = 1'b1;
      i_data_wr_en = 1'b0;
      i_data_addr  = 32'h1000;
      i_inst_rd_en = 1'b1;
      i_inst_addr  = 32'h2000;
    end else if (mode == 2) begin
      i_data_rd_en = 1'b0;
      i_data_wr_en = 1'b0;
      i_inst_rd_en = 1'b0;
      d_hold = 1'b0;
      i_hold = 1'b0;
    end else begin
      if (phase == 2 && kind_d) begin
        if ($urandom % 2 == 0) d_hold = 1'b1;
        else begin
          i_data_rd_en = 1'b0;
          i_data_wr_en = 1'b0;
        end
      end else if (d_hold) begin
        d_hold = 1'b0;
        i_data_rd_en = 1'b0;
        i_data_wr_en = 1'b0;
      end else if (!(i_data_rd_en || i_data_wr_en) && $urandom % 3 == 0) begin
        r = int'($urandom % 4);
        i_data_rd_en = (r != 2);
        i_data_wr_en = (r >= 2);
        i_data_addr  = $urandom;
        i_data_wr    = $urandom;
        i_data_size  = 2'($urandom % 4);
      end
      if (phase == 2 && !kind_d) begin
        if ($urandom % 2 == 0) i_hold = 1'b1;
        else i_inst_rd_en = 1'b0;
      end else if (i_hold) begin
        i_hold = 1'b0;
        i_inst_rd_en = 1'b0;
      end else if (!i_inst_rd_en && $urandom % 3 == 0) begin
        i_inst_rd_en = 1'b1;
        i_inst_addr  = $urandom & 32'hFFFF_FFFC;
      end
    end

    if (phase == 1) begin
      if (new_grant) delay = (mode == 0) ? int'($urandom % 4) : 0;
      if (delay == 0) begin
        mem.ack   = 1'b1;
        mem.rdata = $urandom;
      end else begin
        mem.ack = 1'b0;
        delay--;
      end
    end else begin
      mem.ack   = (mode == 0) && ($urandom % 6 == 0);
      mem.rdata = $urandom;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    mem.ack   = 1'b0;
    mem.rdata = '0;

    // reset state
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();

    // single fetch, ack in first busy cycle
    req_rise = 0;
    i_inst_rd_en = 1'b1;
    i_inst_addr  = 32'h0000_0010;
    step();
    chk("t1_size", mem.size, 2'b10);
    chk("t1_we", mem.we, 0);
    mem.ack   = 1'b1;
    mem.rdata = 32'h00A0_0093;
    step();
    chk("t1_ready", o_instr_ready, 1);
    chk("t1_data", o_instr_data, 32'h00A0_0093);
    i_inst_rd_en = 1'b0;
    mem.ack = 1'b0;
    step();
    chk("t1_ready_gone", o_instr_ready, 0);
    step();
    chk("t1_one_req", req_rise, 1);

    // store, ack delayed; address/data inputs change mid-access
    req_hi = 0;
    i_data_wr_en = 1'b1;
    i_data_addr  = 32'h100;
    i_data_wr    = 32'hDEAD_BEEF;
    i_data_size  = 2'b00;
    step();
    chk("t2_we", mem.we, 1);
    i_data_addr = 32'h200;
    i_data_wr   = 32'h0;
    step();
    step();
    step();
    chk("t2_addr_held", mem.addr, 32'h100);
    chk("t2_wdata_held", mem.wdata, 32'hDEAD_BEEF);
    mem.ack   = 1'b1;
    mem.rdata = 32'h5555_AAAA;
    step();
    chk("t2_ready", o_data_ready, 1);
    chk("t2_rd_kept", o_data_rd, 0);
    chk("t2_req_cycles", req_hi, 4);
    i_data_wr_en = 1'b0;
    mem.ack = 1'b0;
    step();

    // simultaneous load and fetch
    i_data_rd_en = 1'b1;
    i_data_addr  = 32'h40;
    i_inst_rd_en = 1'b1;
    i_inst_addr  = 32'h80;
    step();
    chk("t3_data_first", mem.addr, 32'h40);
    mem.ack   = 1'b1;
    mem.rdata = 32'h1111_1111;
    step();
    i_data_rd_en = 1'b0;
    mem.ack = 1'b0;
    step();
    step();
    chk("t3_fetch_addr", mem.addr, 32'h80);
    mem.ack   = 1'b1;
    mem.rdata = 32'h2222_2222;
    step();
    i_inst_rd_en = 1'b0;
    mem.ack = 1'b0;
    step();
    chk("t3_gap", i_ready_cyc - d_ready_cyc, 3);
    chk("t3_load_data", o_data_rd, 32'h1111_1111);

    // spurious ack while idle
    mem.ack   = 1'b1;
    mem.rdata = 32'hFFFF_FFFF;
    step();
    step();
    chk("t4_spur_req", mem.req, 0);
    chk("t4_spur_ready", o_data_ready | o_instr_ready, 0);
    mem.ack = 1'b0;

    // load enable held through ready cycles
    req_rise = 0;
    i_data_rd_en = 1'b1;
    i_data_addr  = 32'h44;
    for (int k = 0; k < 9; k++) begin
      step();
      if (phase == 1) begin
        mem.ack   = 1'b1;
        mem.rdata = $urandom;
      end else begin
        mem.ack = 1'b0;
      end
    end
    i_data_rd_en = 1'b0;
    mem.ack = 1'b0;
    chk("t4_grants", req_rise, 3);
    step();

    // reset during data access with ack in the same cycle
    i_data_rd_en = 1'b1;
    i_data_addr  = 32'h80;
    step();
    mem.ack   = 1'b1;
    mem.rdata = 32'h1234_5678;
    rst = 1'b1;
    step();
    chk("t5_req", mem.req, 0);
    chk("t5_ready", o_data_ready, 0);
    chk("t5_rd", o_data_rd, 0);
    rst = 1'b0;
    i_data_rd_en = 1'b0;
    mem.ack = 1'b0;
    step();
    chk("t5_idle", mem.req, 0);

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      auto_drive(0);
      step();
    end
    auto_drive(2);
    step();
    for (int k = 0; k < 20 && phase != 0; k++) begin
      auto_drive(2);
      step();
    end
    chk("drain", phase, 0);
    mem.ack = 1'b0;

    // lone load clears the streak before the starvation run
    i_data_rd_en = 1'b1;
    i_data_wr_en = 1'b0;
    i_data_addr  = 32'h1000;
    step();
    mem.ack   = 1'b1;
    mem.rdata = $urandom;
    step();
    i_data_rd_en = 1'b0;
    mem.ack = 1'b0;
    step();

    dut_log.delete();
    for (int k = 0; k < 100 && dut_log.size() < 15; k++) begin
      auto_drive(1);
      step();
    end
    chk("starve_count", dut_log.size() >= 15, 1);
    for (int g = 0; g < 15; g++) begin
      if (g < dut_log.size()) begin
        chk($sformatf("starve_%0d", g), dut_log[g],
            (g % 5 == 4) ? 32'h2000 : 32'h1000);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
